multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32 subset core: ld, sd, beq, R-type add/sub/and/or.
- Sequences the shared ALU, memory port, IR, PC and register file across FETCH/DECODE/EXECUTE/MEM/WB states.
- Drives the 2-bit aluOp consumed by the existing funct-decoding ALU control block.
- Handles variable-latency memory through a memReady handshake and keeps a retired-instruction counter.

Parameters:
- CNT_WIDTH, 32, width of retired-instruction counter instrCount

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- zero  in  1  ALU zero flag (datapath gates pcWriteCond with it)
- memReady  in  1  memory completes current read/write this cycle
- pcWrite  out  1  unconditional PC load
- pcWriteCond  out  1  PC load if zero
- pcSource  out  1  0=ALU result, 1=ALUOut register
- iorD  out  1  memory address: 0=PC, 1=ALUOut
- memRead  out  1  memory read request
- memWrite  out  1  memory write request
- irWrite  out  1  IR load
- memToReg  out  1  regfile write data: 0=ALUOut, 1=MDR
- regWrite  out  1  regfile write enable
- aluSrcA  out  1  0=PC/oldPC, 1=rs1
- aluSrcB  out  2  00=rs2, 01=const 4, 10=immediate
- aluOp  out  2  00=add, 01=sub, 10=funct-decoded
- instrDone  out  1  one-cycle pulse per retired instruction
- illegalInstr  out  1  one-cycle pulse on unsupported opcode
- instrCount  out  CNT_WIDTH  retired-instruction count

Behaviour:
- States: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, TRAP. Encoding is shared (see Decomposition).
- Reset (rst_n=0, async): state=IDLE, instrCount=0. Every output is 0, including aluOp=00 and aluSrcB=00.
- Outputs are Moore-decoded from state. The only exceptions are the memReady-gated strobes noted below. Any output not listed for a state is 0.
- IDLE: all outputs 0. Goes to FETCH next cycle unconditionally, so the first fetch request starts one cycle after reset release.
- FETCH:
  - memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=0.
  - irWrite=pcWrite=memReady (Mealy).
  - Stays while memReady=0; goes to DECODE when memReady=1.
- DECODE: aluSrcA=0, aluSrcB=10, aluOp=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTE
  - 1100011 -> BRANCH
  - anything else -> TRAP
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Goes to MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: memRead=1, iorD=1. Waits for memReady, then MEMWB.
- MEMWB: regWrite=1, memToReg=1, instrDone=1. Then FETCH.
- MEMWRITE: memWrite=1, iorD=1. Waits for memReady. On memReady: instrDone=1 (Mealy), then FETCH.
- EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10. Then ALUWB.
- ALUWB: regWrite=1, memToReg=0, instrDone=1. Then FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=1, instrDone=1. Then FETCH. instrDone fires whether or not the branch is taken.
- TRAP: illegalInstr=1 for exactly one cycle. instrCount is not incremented. Then FETCH, so the PC has already advanced past the bad instruction.
- Memory requests:
  - memRead/memWrite stay asserted and stable while waiting.
  - No wait-cycle limit.
  - memReady is ignored in states without a request.
- instrCount:
  - Increments in the same cycle instrDone=1. The new value is visible the next cycle.
  - Wraps from all-ones to 0 with no flag.
- Reset mid-instruction: an immediate return to IDLE, outputs 0, counter cleared. A pending memory request is dropped with no completion.
- Cycle counts with memReady tied to 1: ld=5, sd=4, R-type=4, beq=3.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state encoding constants S_IDLE..S_TRAP (4-bit)
  - opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH
  - aluOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - aluSrcB select constants
- One sub-module, ctrl_output_decode: purely combinational state+memReady -> control outputs. The FSM and counter stay in multicycle_control.

Test Plan:
- Reset check: rst_n low, then released, memReady=1 -> all outputs 0 and instrCount=0 during reset; IDLE for one cycle, then memRead=1 with aluSrcB=01 next cycle.
- R-type with memReady=1, opcode=0110011 -> states FETCH, DECODE, EXECUTE (aluOp=10, aluSrcB=00), ALUWB (regWrite=1, instrDone=1); instrCount 0->1 after 4 cycles.
- ld with 3 wait cycles in MEMREAD, opcode=0000011 -> memRead=1 and iorD=1 held 4 cycles; MEMWB asserts regWrite=1 and memToReg=1; instruction takes 8 cycles.
- Back-to-back sd then beq, memReady=1 -> sd: instrDone pulse in MEMWRITE with memWrite=1; beq: pcWriteCond=1, aluOp=01, pcSource=1 for one cycle; instrCount=2.
- Illegal opcode 1111111 -> TRAP with illegalInstr=1 for one cycle, instrCount unchanged, FETCH next cycle.
- rst_n pulsed low during MEMREAD wait -> outputs drop to 0 asynchronously; instrCount=0; FETCH resumes two cycles after release. Separately, with instrCount forced to all-ones (CNT_WIDTH=4, 15 retirements), the next retirement wraps it to 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path: FSM states, opcodes, ALU selects.
// Latency: n/a (constants, types and one pure function only).
// Backpressure: n/a.
//
// Contents:
//   state_t / S_*         4-bit FSM state encoding shared by the FSM and the output decoder
//   OP_*                  major opcodes of the supported subset (ld, sd, R-type, beq)
//   ALUOP_*               2-bit aluOp values consumed by the funct-decoding ALU control
//   SRCB_*                aluSrcB mux selects
//   ctrl_t                packed bundle of every control strobe the decoder produces
//   decode_dispatch()     DECODE-state opcode dispatch
package riscv_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_FETCH    = 4'd1;
  localparam state_t S_DECODE   = 4'd2;
  localparam state_t S_MEMADR   = 4'd3;
  localparam state_t S_MEMREAD  = 4'd4;
  localparam state_t S_MEMWB    = 4'd5;
  localparam state_t S_MEMWRITE = 4'd6;
  localparam state_t S_EXECUTE  = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;
  localparam state_t S_TRAP     = 4'd10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;  // rs2
  localparam logic [1:0] SRCB_FOUR = 2'b01;  // constant 4 (PC increment)
  localparam logic [1:0] SRCB_IMM  = 2'b10;  // sign-extended immediate

  // Every control strobe in one packed word so the decoder can default
  // the whole set to zero with a single assignment.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_instr;
  } ctrl_t;

  // Opcode dispatch out of DECODE. Anything outside the supported subset
  // traps; loads and stores share the address-calculation state.
  function automatic state_t decode_dispatch(input logic [6:0] op);
    state_t nxt;
    case (op)
      OP_LOAD,
      OP_STORE:  nxt = S_MEMADR;
      OP_RTYPE:  nxt = S_EXECUTE;
      OP_BRANCH: nxt = S_BRANCH;
      default:   nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Control-strobe decoder for the multicycle FSM: state (+memReady) -> datapath controls.
// Latency: purely combinational, zero cycles.
// Backpressure: memReady only qualifies the completion strobes of FETCH and MEMWRITE.
//
// Ports:
//   state_i            current FSM state
//   mem_ready_i        memory completes its current access this cycle
//   *_o                datapath control strobes (see riscv_ctrl_pkg::ctrl_t)
module ctrl_output_decode
  import riscv_ctrl_pkg::*;
(
  input  logic       state_i_unused_guard_n,
  input  state_t     state_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       pc_source_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       instr_done_o,
  output logic       illegal_instr_o
);

  ctrl_t ctrl;

  always_comb begin
    ctrl = '0;
    case (state_i)
      S_FETCH: begin
        // PC+4 is computed while the instruction is read; IR and PC are
        // only loaded in the cycle the memory actually returns data.
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = 1'b0;
        ctrl.ir_write  = mem_ready_i;
        ctrl.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        // Speculative branch target (PC + imm) lands in ALUOut.
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        // A store retires in the cycle its write is accepted.
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready_i;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        // Compare rs1-rs2; the datapath ANDs pcWriteCond with zero, so the
        // instruction retires here whether or not the branch is taken.
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
        ctrl.instr_done    = 1'b1;
      end
      S_TRAP: begin
        ctrl.illegal_instr = 1'b1;
      end
      default: begin
        ctrl = '0;  // IDLE and unused encodings drive nothing
      end
    endcase
  end

  assign pc_write_o      = ctrl.pc_write      & state_i_unused_guard_n;
  assign pc_write_cond_o = ctrl.pc_write_cond & state_i_unused_guard_n;
  assign pc_source_o     = ctrl.pc_source     & state_i_unused_guard_n;
  assign iord_o          = ctrl.iord          & state_i_unused_guard_n;
  assign mem_read_o      = ctrl.mem_read      & state_i_unused_guard_n;
  assign mem_write_o     = ctrl.mem_write     & state_i_unused_guard_n;
  assign ir_write_o      = ctrl.ir_write      & state_i_unused_guard_n;
  assign mem_to_reg_o    = ctrl.mem_to_reg    & state_i_unused_guard_n;
  assign reg_write_o     = ctrl.reg_write     & state_i_unused_guard_n;
  assign alu_src_a_o     = ctrl.alu_src_a     & state_i_unused_guard_n;
  assign alu_src_b_o     = ctrl.alu_src_b     & {2{state_i_unused_guard_n}};
  assign alu_op_o        = ctrl.alu_op        & {2{state_i_unused_guard_n}};
  assign instr_done_o    = ctrl.instr_done    & state_i_unused_guard_n;
  assign illegal_instr_o = ctrl.illegal_instr & state_i_unused_guard_n;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32 subset core (ld, sd, beq, add/sub/and/or).
// Latency: Moore outputs per state; ld=5, sd=4, R-type=4, beq=3 cycles with memReady held high.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold their request stable until memReady; no timeout.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   opcode                IR[6:0], meaningful from DECODE onward
//   zero                  ALU zero flag; the datapath gates pcWriteCond with it
//   memReady              memory completes the current read/write this cycle
//   pcWrite..aluOp        datapath control strobes
//   instrDone             one-cycle pulse per retired instruction
//   illegalInstr          one-cycle pulse on an unsupported opcode
//   instrCount            retired-instruction counter, wraps silently
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  input  logic                 memReady,
  output logic                 pcWrite,
  output logic                 pcWriteCond,
  output logic                 pcSource,
  output logic                 iorD,
  output logic                 memRead,
  output logic                 memWrite,
  output logic                 irWrite,
  output logic                 memToReg,
  output logic                 regWrite,
  output logic                 aluSrcA,
  output logic [1:0]           aluSrcB,
  output logic [1:0]           aluOp,
  output logic                 instrDone,
  output logic                 illegalInstr,
  output logic [CNT_WIDTH-1:0] instrCount
);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] instr_count_q, instr_count_d;
  logic                 instr_done;

  // The branch decision is made in the datapath (pcWriteCond & zero), so
  // the flag is only carried through this block's interface.
  logic zero_unused;
  assign zero_unused = zero;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (memReady) state_d = S_DECODE;
      S_DECODE:   state_d = decode_dispatch(opcode);
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (memReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (memReady) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      // PC was already advanced in FETCH, so the bad instruction is skipped.
      S_TRAP:     state_d = S_FETCH;
      default:    state_d = S_IDLE;  // recover from an unused encoding
    endcase
  end

  // -------------------------------------------------------------- outputs
  ctrl_output_decode u_decode (
    .state_i_unused_guard_n (1'b1),
    .state_i                (state_q),
    .mem_ready_i            (memReady),
    .pc_write_o             (pcWrite),
    .pc_write_cond_o        (pcWriteCond),
    .pc_source_o            (pcSource),
    .iord_o                 (iorD),
    .mem_read_o             (memRead),
    .mem_write_o            (memWrite),
    .ir_write_o             (irWrite),
    .mem_to_reg_o           (memToReg),
    .reg_write_o            (regWrite),
    .alu_src_a_o            (aluSrcA),
    .alu_src_b_o            (aluSrcB),
    .alu_op_o               (aluOp),
    .instr_done_o           (instr_done),
    .illegal_instr_o        (illegalInstr)
  );

  assign instrDone = instr_done;

  // ---------------------------------------------- retired-instruction count
  // Bumped on the retirement cycle itself; wraps to zero with no flag.
  always_comb begin
    instr_count_d = instr_count_q;
    if (instr_done) begin
      instr_count_d = instr_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count_q <= '0;
    end else begin
      instr_count_q <= instr_count_d;
    end
  end

  assign instrCount = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int W = 4;

  // Expected control vectors, bit order:
  // pcWrite pcWriteCond pcSource iorD memRead memWrite irWrite memToReg
  // regWrite aluSrcA aluSrcB[1:0] aluOp[1:0] instrDone illegalInstr
  localparam logic [15:0] E_ZERO      = 16'b0_0_0_0_0_0_0_0_0_0_00_00_0_0;
  localparam logic [15:0] E_FETCH_RDY = 16'b1_0_0_0_1_0_1_0_0_0_01_00_0_0;
  localparam logic [15:0] E_FETCH_WT  = 16'b0_0_0_0_1_0_0_0_0_0_01_00_0_0;
  localparam logic [15:0] E_DECODE    = 16'b0_0_0_0_0_0_0_0_0_0_10_00_0_0;
  localparam logic [15:0] E_MEMADR    = 16'b0_0_0_0_0_0_0_0_0_1_10_00_0_0;
  localparam logic [15:0] E_MEMREAD   = 16'b0_0_0_1_1_0_0_0_0_0_00_00_0_0;
  localparam logic [15:0] E_MEMWB     = 16'b0_0_0_0_0_0_0_1_1_0_00_00_1_0;
  localparam logic [15:0] E_MEMWR_WT  = 16'b0_0_0_1_0_1_0_0_0_0_00_00_0_0;
  localparam logic [15:0] E_MEMWR_RDY = 16'b0_0_0_1_0_1_0_0_0_0_00_00_1_0;
  localparam logic [15:0] E_EXEC      = 16'b0_0_0_0_0_0_0_0_0_1_00_10_0_0;
  localparam logic [15:0] E_ALUWB     = 16'b0_0_0_0_0_0_0_0_1_0_00_00_1_0;
  localparam logic [15:0] E_BRANCH    = 16'b0_1_1_0_0_0_0_0_0_1_00_01_1_0;
  localparam logic [15:0] E_TRAP      = 16'b0_0_0_0_0_0_0_0_0_0_00_00_0_1;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] SD  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [6:0]   opcode;
  logic         zero;
  logic         memReady;
  logic         pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite;
  logic         irWrite, memToReg, regWrite, aluSrcA, instrDone, illegalInstr;
  logic [1:0]   aluSrcB, aluOp;
  logic [W-1:0] instrCount;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .zero         (zero),
    .memReady     (memReady),
    .pcWrite      (pcWrite),
    .pcWriteCond  (pcWriteCond),
    .pcSource     (pcSource),
    .iorD         (iorD),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .irWrite      (irWrite),
    .memToReg     (memToReg),
    .regWrite     (regWrite),
    .aluSrcA      (aluSrcA),
    .aluSrcB      (aluSrcB),
    .aluOp        (aluOp),
    .instrDone    (instrDone),
    .illegalInstr (illegalInstr),
    .instrCount   (instrCount)
  );

  logic [15:0] act;
  assign act = {pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite, irWrite,
                memToReg, regWrite, aluSrcA, aluSrcB, aluOp, instrDone, illegalInstr};

  typedef struct {
    logic [15:0] ctrl;
    int          cnt;
    int          idx;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_push = 0;

  // Monitor: the DUT presents a full control word every cycle; each one that
  // has an expectation queued is compared at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        total++;
        if (act !== e.ctrl) begin
          bad++;
          $display("FAIL ctrl[%0d]: got %b want %b", e.idx, act, e.ctrl);
        end
        total++;
        if (instrCount !== W'(e.cnt)) begin
          bad++;
          $display("FAIL count[%0d]: got %0d want %0d", e.idx, instrCount, W'(e.cnt));
        end
      end
    end
  end

  task automatic expect_now(input logic [15:0] ev, input int cnt);
    exp_t e;
    e.ctrl = ev;
    e.cnt  = cnt;
    e.idx  = n_push;
    n_push++;
    q.push_back(e);
  endtask

  // Drive one cycle's inputs, queue what the DUT must show in that cycle.
  task automatic cyc(input logic rdy, input logic [6:0] op,
                     input logic [15:0] ev, input int cnt);
    memReady = rdy;
    opcode   = op;
    zero     = 1'($urandom_range(0, 1));
    expect_now(ev, cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    memReady = 1'b1;
    opcode   = 7'd0;
    zero     = 1'b0;
    @(posedge clk);
    #1;

    // Reset held: everything zero, counter zero.
    cyc(1'b1, 7'd0, E_ZERO, 0);
    cyc(1'b1, 7'd0, E_ZERO, 0);
    rst_n = 1'b1;
    cyc(1'b1, 7'd0, E_ZERO, 0);          // IDLE one cycle

    // R-type: 4 cycles
    cyc(1'b1, RT, E_FETCH_RDY, 0);
    cyc(1'b1, RT, E_DECODE,    0);
    cyc(1'b1, RT, E_EXEC,      0);
    cyc(1'b1, RT, E_ALUWB,     0);

    // ld with 3 wait states; memReady low in non-request states is ignored
    cyc(1'b1, LD, E_FETCH_RDY, 1);
    cyc(1'b0, LD, E_DECODE,    1);
    cyc(1'b0, LD, E_MEMADR,    1);
    cyc(1'b0, LD, E_MEMREAD,   1);
    cyc(1'b0, LD, E_MEMREAD,   1);
    cyc(1'b0, LD, E_MEMREAD,   1);
    cyc(1'b1, LD, E_MEMREAD,   1);
    cyc(1'b0, LD, E_MEMWB,     1);

    // sd then beq back to back
    cyc(1'b1, SD,  E_FETCH_RDY, 2);
    cyc(1'b1, SD,  E_DECODE,    2);
    cyc(1'b1, SD,  E_MEMADR,    2);
    cyc(1'b1, SD,  E_MEMWR_RDY, 2);
    cyc(1'b1, BEQ, E_FETCH_RDY, 3);
    cyc(1'b1, BEQ, E_DECODE,    3);
    cyc(1'b1, BEQ, E_BRANCH,    3);

    // Illegal opcode after a fetch wait state
    cyc(1'b0, BAD, E_FETCH_WT,  4);
    cyc(1'b1, BAD, E_FETCH_RDY, 4);
    cyc(1'b1, BAD, E_DECODE,    4);
    cyc(1'b1, BAD, E_TRAP,      4);

    // sd with one write wait state
    cyc(1'b1, SD, E_FETCH_RDY, 4);
    cyc(1'b1, SD, E_DECODE,    4);
    cyc(1'b1, SD, E_MEMADR,    4);
    cyc(1'b0, SD, E_MEMWR_WT,  4);
    cyc(1'b1, SD, E_MEMWR_RDY, 4);

    // ld interrupted by reset while waiting in MEMREAD
    cyc(1'b1, LD, E_FETCH_RDY, 5);
    cyc(1'b1, LD, E_DECODE,    5);
    cyc(1'b1, LD, E_MEMADR,    5);
    cyc(1'b0, LD, E_MEMREAD,   5);
    memReady = 1'b0;
    expect_now(E_ZERO, 0);               // sampled after async reset, before any edge
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, LD, E_ZERO, 0);
    rst_n = 1'b1;
    cyc(1'b1, LD, E_ZERO, 0);            // IDLE
    // 16 branches: counter walks to 15, then wraps to 0
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, BEQ, E_FETCH_RDY, i);
      cyc(1'b1, BEQ, E_DECODE,    i);
      cyc(1'b1, BEQ, E_BRANCH,    i);
    end
    cyc(1'b1, RT, E_FETCH_RDY, 0);

    // Let the monitor drain the last expectation, bounded.
    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
